// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encodings for the
// registered MaquinaSencilla ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_NOTB  = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_AND   = 3'd5;
  localparam logic [2:0] OP_SHL   = 3'd6;
  localparam logic [2:0] OP_MUL   = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MUL   = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control
// unit and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             z;
  logic             n;
  logic             c;
  logic             v;

  modport master (
    output start, op, a, b,
    input  ready, out, done, z, n, c, v
  );

  modport slave (
    input  start, op, a, b,
    output ready, out, done, z, n, c, v
  );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle ops 0-5 with their
// carry and overflow flags.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) &&
              (sum[WIDTH-1] != a[WIDTH-1]);
      end
      (op == OP_XOR):   res = a ^ b;
      (op == OP_PASSB): res = b;
      (op == OP_NOTB):  res = ~b;
      (op == OP_SUB): begin
        res = dif[WIDTH-1:0];
        // top bit of the widened difference is the borrow
        c   = ~dif[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) &&
              (dif[WIDTH-1] != a[WIDTH-1]);
      end
      (op == OP_AND):   res = a & b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops plus
// iterative shift-left and shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic   clk,
  input  logic   reset_n,
  alu_seq_if.slave bus
);

  logic [1:0]         state;
  logic [SW-1:0]      cnt;
  logic [SW-1:0]      k;
  logic [WIDTH-1:0]   sh;
  logic [WIDTH-1:0]   out_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_nx;
  logic               done_r;
  logic               z_r, n_r, c_r, v_r;
  logic               accept;
  logic               single;
  logic [WIDTH-1:0]   core_res;
  logic [WIDTH-1:0]   s_res;
  logic               core_c, core_v;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op  (bus.op),
    .a   (bus.a),
    .b   (bus.b),
    .res (core_res),
    .c   (core_c),
    .v   (core_v)
  );

  assign k      = bus.b[SW-1:0];
  assign accept = bus.start && (state == ST_IDLE);
  assign single = (bus.op < OP_SHL) ||
                  ((bus.op == OP_SHL) && (k == '0));
  // SHL by zero takes the single-cycle path
  assign s_res  = (bus.op == OP_SHL) ? bus.a : core_res;
  assign acc_nx = acc + (sh[0] ? mcand : '0);

  assign bus.ready = (state == ST_IDLE);
  assign bus.out   = out_r;
  assign bus.done  = done_r;
  assign bus.z     = z_r;
  assign bus.n     = n_r;
  assign bus.c     = c_r;
  assign bus.v     = v_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sh     <= '0;
      acc    <= '0;
      mcand  <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
      z_r    <= 1'b1;
      n_r    <= 1'b0;
      c_r    <= 1'b0;
      v_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && single) begin
            out_r  <= s_res;
            z_r    <= (s_res == '0);
            n_r    <= s_res[WIDTH-1];
            c_r    <= core_c;
            v_r    <= core_v;
            done_r <= 1'b1;
          end else if (accept && bus.op == OP_SHL) begin
            sh    <= bus.a;
            cnt   <= k;
            state <= ST_SHIFT;
          end else if (accept) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, bus.a};
            sh    <= bus.b;
            cnt   <= '0;
            state <= ST_MUL;
          end
        end
        ST_SHIFT: begin
          sh  <= sh << 1;
          cnt <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            out_r  <= sh << 1;
            z_r    <= ((sh << 1) == '0);
            n_r    <= sh[WIDTH-2];
            c_r    <= sh[WIDTH-1];
            v_r    <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc   <= acc_nx;
          mcand <= mcand << 1;
          sh    <= sh >> 1;
          cnt   <= cnt + 1'b1;
          // WIDTH is a power of two, so all-ones marks the last step
          if (cnt == '1) begin
            out_r  <= acc_nx[WIDTH-1:0];
            z_r    <= (acc_nx[WIDTH-1:0] == '0);
            n_r    <= acc_nx[WIDTH-1];
            c_r    <= |acc_nx[2*WIDTH-1:WIDTH];
            v_r    <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq
// at WIDTH=16 and WIDTH=8.
module tb_alu_seq;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total;

  alu_seq_if #(.WIDTH(16)) b16 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(16)) u16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b16)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue16(input logic [2:0] op,
                         input logic [15:0] a,
                         input logic [15:0] b);
    b16.start = 1'b1;
    b16.op    = op;
    b16.a     = a;
    b16.b     = b;
    @(posedge clk);
    @(negedge clk);
    b16.start = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({b16.ready, b16.done} !== 2'b10)
      $display("FAIL rst_rdy_done got %b want 10",
               {b16.ready, b16.done});
    else pass_cnt++;
    total++;
    if (b16.out !== 16'h0000)
      $display("FAIL rst_out got %h want 0000", b16.out);
    else pass_cnt++;
    total++;
    if ({b16.z, b16.n, b16.c, b16.v} !== 4'b1000)
      $display("FAIL rst_flags got %b want 1000",
               {b16.z, b16.n, b16.c, b16.v});
    else pass_cnt++;
  endtask

  task automatic test_add();
    issue16(3'd0, 16'h7FFF, 16'h0001);
    total++;
    if ({b16.done, b16.ready, b16.out} !== {2'b11, 16'h8000})
      $display("FAIL add_ovf got %b/%b/%h want 1/1/8000",
               b16.done, b16.ready, b16.out);
    else pass_cnt++;
    total++;
    if ({b16.z, b16.n, b16.c, b16.v} !== 4'b0101)
      $display("FAIL add_ovf_flags got %b want 0101",
               {b16.z, b16.n, b16.c, b16.v});
    else pass_cnt++;
    issue16(3'd0, 16'hFFFF, 16'h0001);
    total++;
    if ({b16.done, b16.out} !== {1'b1, 16'h0000})
      $display("FAIL add_carry got %b/%h want 1/0000",
               b16.done, b16.out);
    else pass_cnt++;
    total++;
    if ({b16.z, b16.n, b16.c, b16.v} !== 4'b1010)
      $display("FAIL add_carry_flags got %b want 1010",
               {b16.z, b16.n, b16.c, b16.v});
    else pass_cnt++;
  endtask

  task automatic test_sub();
    issue16(3'd4, 16'd5, 16'd7);
    total++;
    if ({b16.out, b16.z, b16.n, b16.c, b16.v} !==
        {16'hFFFE, 4'b0100})
      $display("FAIL sub_borrow got %h/%b want fffe/0100",
               b16.out, {b16.z, b16.n, b16.c, b16.v});
    else pass_cnt++;
    issue16(3'd4, 16'd7, 16'd5);
    total++;
    if ({b16.out, b16.z, b16.n, b16.c, b16.v} !==
        {16'h0002, 4'b0010})
      $display("FAIL sub_nob got %h/%b want 0002/0010",
               b16.out, {b16.z, b16.n, b16.c, b16.v});
    else pass_cnt++;
    issue16(3'd3, 16'h1234, 16'h00FF);
    total++;
    if ({b16.out, b16.z, b16.n, b16.c, b16.v} !==
        {16'hFF00, 4'b0100})
      $display("FAIL notb got %h/%b want ff00/0100",
               b16.out, {b16.z, b16.n, b16.c, b16.v});
    else pass_cnt++;
  endtask

  task automatic test_shl();
    int lat;
    int low;
    logic [15:0] o;
    logic cf;
    lat = 0;
    low = 0;
    o   = 'x;
    cf  = 'x;
    issue16(3'd6, 16'h8001, 16'd3);
    total++;
    if ({b16.done, b16.out} !== {1'b0, 16'hFF00})
      $display("FAIL shl_busy got %b/%h want 0/ff00",
               b16.done, b16.out);
    else pass_cnt++;
    if (!b16.ready) low++;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!b16.ready) low++;
      if (b16.done && lat == 0) begin
        lat = i;
        o   = b16.out;
        cf  = b16.c;
      end
    end
    total++;
    if (lat != 3 || low != 3)
      $display("FAIL shl_timing got lat=%0d low=%0d want 3/3",
               lat, low);
    else pass_cnt++;
    total++;
    if ({o, cf} !== {16'h0008, 1'b0})
      $display("FAIL shl3 got %h/%b want 0008/0", o, cf);
    else pass_cnt++;
    issue16(3'd6, 16'h8001, 16'd1);
    @(negedge clk);
    total++;
    if ({b16.done, b16.out, b16.c} !== {1'b1, 16'h0002, 1'b1})
      $display("FAIL shl1 got %b/%h/%b want 1/0002/1",
               b16.done, b16.out, b16.c);
    else pass_cnt++;
    issue16(3'd6, 16'h8001, 16'd16);
    total++;
    if ({b16.done, b16.ready, b16.out, b16.n, b16.c} !==
        {2'b11, 16'h8001, 2'b10})
      $display("FAIL shl0 got %b/%b/%h/%b%b want 1/1/8001/10",
               b16.done, b16.ready, b16.out, b16.n, b16.c);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat;
    int pulses;
    int held;
    logic [15:0] o;
    logic cf;
    lat    = 0;
    pulses = 0;
    held   = 1;
    o      = 'x;
    cf     = 'x;
    issue16(3'd7, 16'd300, 16'd300);
    for (int i = 1; i <= 24; i++) begin
      if (i == 5) begin
        b16.start = 1'b1;
        b16.op    = 3'd0;
        b16.a     = 16'd1;
        b16.b     = 16'd1;
      end
      @(negedge clk);
      b16.start = 1'b0;
      if (b16.done) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          o   = b16.out;
          cf  = b16.c;
        end
      end else if (lat == 0 && b16.out !== 16'h8001) begin
        held = 0;
      end
    end
    total++;
    if (lat != 16 || pulses != 1)
      $display("FAIL mul_timing got lat=%0d pulses=%0d want 16/1",
               lat, pulses);
    else pass_cnt++;
    total++;
    if (held != 1)
      $display("FAIL mul_out_hold got %0d want 1", held);
    else pass_cnt++;
    total++;
    if ({o, cf} !== {16'h5F90, 1'b1})
      $display("FAIL mul300 got %h/%b want 5f90/1", o, cf);
    else pass_cnt++;
    issue16(3'd7, 16'd12, 16'd11);
    lat = 0;
    for (int i = 1; i <= 24 && lat == 0; i++) begin
      @(negedge clk);
      if (b16.done) lat = i;
    end
    total++;
    if (lat != 16 || {b16.out, b16.z, b16.c} !== {16'd132, 2'b00})
      $display("FAIL mul12 got lat=%0d %h/%b%b want 16 0084/00",
               lat, b16.out, b16.z, b16.c);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [4];
    logic [15:0] av  [4];
    logic [15:0] bv  [4];
    logic [15:0] ex  [4];
    ops = '{3'd1, 3'd5, 3'd2, 3'd0};
    av  = '{16'h00F0, 16'h00F0, 16'hAAAA, 16'h0001};
    bv  = '{16'h0FF0, 16'h0FF0, 16'h1234, 16'h0002};
    ex  = '{16'h0F00, 16'h00F0, 16'h1234, 16'h0003};
    b16.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b16.op = ops[i];
      b16.a  = av[i];
      b16.b  = bv[i];
      @(negedge clk);
      total++;
      if ({b16.done, b16.out} !== {1'b1, ex[i]})
        $display("FAIL b2b_%0d got %b/%h want 1/%h",
                 i, b16.done, b16.out, ex[i]);
      else pass_cnt++;
    end
    b16.start = 1'b0;
  endtask

  task automatic test_width8();
    logic [7:0] ex [2];
    logic [3:0] fl [2];
    logic [7:0] av [2];
    int lat;
    av = '{8'h7F, 8'hFF};
    ex = '{8'h80, 8'h00};
    fl = '{4'b0101, 4'b1010};
    b8.start = 1'b1;
    b8.op    = 3'd0;
    b8.b     = 8'h01;
    for (int i = 0; i < 2; i++) begin
      b8.a = av[i];
      @(negedge clk);
      total++;
      if ({b8.done, b8.out, b8.z, b8.n, b8.c, b8.v} !==
          {1'b1, ex[i], fl[i]})
        $display("FAIL w8_add_%0d got %b/%h/%b want 1/%h/%b",
                 i, b8.done, b8.out,
                 {b8.z, b8.n, b8.c, b8.v}, ex[i], fl[i]);
      else pass_cnt++;
    end
    b8.op = 3'd7;
    b8.a  = 8'd16;
    b8.b  = 8'd16;
    @(posedge clk);
    @(negedge clk);
    b8.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 16 && lat == 0; i++) begin
      @(negedge clk);
      if (b8.done) lat = i;
    end
    total++;
    if (lat != 8 || {b8.out, b8.z, b8.c} !== {8'h00, 2'b11})
      $display("FAIL w8_mul got lat=%0d %h/%b%b want 8 00/11",
               lat, b8.out, b8.z, b8.c);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    int pulses;
    pulses = 0;
    issue16(3'd7, 16'd3, 16'd5);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({b16.ready, b16.done, b16.out, b16.z} !==
        {2'b10, 16'h0000, 1'b1})
      $display("FAIL rst_mid_mul got %b/%b/%h/%b want 1/0/0000/1",
               b16.ready, b16.done, b16.out, b16.z);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (b16.done) pulses++;
    end
    total++;
    if (pulses != 0 || b16.out !== 16'h0000)
      $display("FAIL rst_no_done got %0d/%h want 0/0000",
               pulses, b16.out);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    reset_n  = 1'b0;
    b16.start = 1'b0;
    b16.op    = '0;
    b16.a     = '0;
    b16.b     = '0;
    b8.start  = 1'b0;
    b8.op     = '0;
    b8.a      = '0;
    b8.b      = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_shl();
    test_mul();
    test_back_to_back();
    test_width8();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered ALU for the MaquinaSencilla datapath. It replaces the 16-bit combinational ALU. Ops 0-3 keep their existing encodings and results. It adds SUB, AND, a multi-cycle left shift and a multi-cycle iterative multiply. Results and a full N/Z/C/V flag set are registered and returned through a start/ready/done handshake to the control unit.

Parameters:
WIDTH, 16, datapath width in bits; must be a power of two, minimum 4.
SW, $clog2(WIDTH), shift-amount bit count (derived; do not override).

Ports:
clk      input   1      system clock, rising edge
reset_n  input   1      asynchronous, active-low reset
start    input   1      request; accepted only when ready=1
ready    output  1      1 = idle, can accept start
op       input   3      operation code, sampled at acceptance
a        input   WIDTH  operand A, sampled at acceptance
b        input   WIDTH  operand B, sampled at acceptance
out      output  WIDTH  registered result
done     output  1      one-cycle pulse: out/flags just updated
z        output  1      out == 0
n        output  1      out[WIDTH-1]
c        output  1      carry / no-borrow / shift-out / multiply-overflow
v        output  1      signed overflow

Behaviour:
- Reset (async, reset_n=0): state IDLE, ready=1, out=0, done=0, z=1, n=0, c=0, v=0. Internal counters and shift/accumulator registers clear. A reset during SHIFT or MUL aborts the operation and produces no done.
- Acceptance: at a rising edge E0 with start=1 and ready=1, latch op, a and b. start while ready=0 is ignored; it is neither queued nor disruptive.
- Op encoding and results (all results modulo 2^WIDTH):
  - 0 ADD: a+b.
  - 1 XOR: a^b.
  - 2 PASSB: b.
  - 3 NOTB: ~b.
  - 4 SUB: a-b.
  - 5 AND: a&b.
  - 6 SHL: a << k, where k = b[SW-1:0].
  - 7 MUL: low WIDTH bits of unsigned a*b.
- Single-cycle ops (0-5, and SHL with k=0):
  - Result and flags commit at E0 itself.
  - done=1 for the cycle following E0; ready stays 1.
  - Back-to-back start every cycle is legal.
- SHL with k>0:
  - E0 loads the shift register with a and the counter with k; state SHIFT, ready=0.
  - Edges E1..Ek each shift left by one.
  - At Ek: commit, state IDLE, done pulse.
  - Latency k cycles beyond E0.
- MUL:
  - E0 loads the accumulator with 0, the multiplicand with a, the multiplier with b; state MUL, ready=0.
  - Edges E1..E_WIDTH each perform one shift-add step on one multiplier bit, LSB first.
  - Commit and done at E_WIDTH.
- States: IDLE, SHIFT, MUL. Transitions:
  - IDLE->SHIFT on accepted SHL with k>0.
  - IDLE->MUL on accepted MUL.
  - SHIFT->IDLE when the counter reaches its last step.
  - MUL->IDLE after WIDTH steps.
- Flags commit only with done. They hold their value otherwise, including throughout busy cycles.
  - z = (out==0).
  - n = out MSB.
  - c by op:
    - ADD: carry out.
    - SUB: 1 when a>=b unsigned (no borrow).
    - SHL: last bit shifted out of the MSB; 0 if k=0.
    - MUL: 1 if the upper WIDTH bits of the full product are non-zero.
    - All other ops: 0.
  - v by op:
    - ADD/SUB: two's-complement overflow.
    - All other ops: 0.
- out holds its value between operations. It does not change while busy.
- done never asserts in two consecutive cycles for multi-cycle ops. For single-cycle ops it may, when start is held high.

Decomposition:
- Package alu_pkg holds:
  - localparams OP_ADD=0, OP_XOR=1, OP_PASSB=2, OP_NOTB=3, OP_SUB=4, OP_AND=5, OP_SHL=6, OP_MUL=7;
  - state encodings ST_IDLE, ST_SHIFT, ST_MUL.
- One sub-module, alu_comb_core (parametrised by WIDTH): purely combinational ops 0-5 and their c/v generation. alu_seq owns the FSM, shift/multiply datapaths, registers and flag muxing.

Test Plan:
- Reset mid-MUL: WIDTH=16, start MUL a=3 b=5; assert reset_n=0 at cycle 4 -> out=0, z=1, ready=1 immediately; no done ever pulses.
- ADD carry/overflow: a=16'h7FFF, b=1 -> out=16'h8000, n=1, v=1, c=0, done at E0+1. Then a=16'hFFFF, b=1 -> out=0, z=1, c=1, v=0.
- SUB borrow: a=5, b=7 -> out=16'hFFFE, c=0, n=1. Then a=7, b=5 -> out=2, c=1. NOTB b=16'h00FF -> 16'hFF00.
- SHL timing: a=16'h8001, b=3 -> ready low for 3 cycles, done at E3, out=16'h0008, c=0. Then b=1 -> out=16'h0002, c=1. Then b=16 (k=0) -> single-cycle, out=a.
- MUL: a=300, b=300 -> done exactly 16 edges after E0, out=16'h5F90, c=1. Then a=12, b=11 -> out=132, c=0. A start pulsed mid-operation is ignored.
- Back-to-back: start held for 4 cycles with XOR/AND/PASSB/ADD -> four consecutive done pulses, each out matching its op. Repeat ADD at WIDTH=8.
